// File: rtl/peripheral_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_uart_rx
// Brief    : 8N1 UART receiver with receive FIFO and J1 IO-bus register
//            interface (data pop at 0x0, status at 0x2, control at 0x4).
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
    localparam int c_PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_FCNT_W       = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(c_HALF_BIT - 1);
    localparam logic [c_FCNT_W-1:0] c_FULL      = c_FCNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_rx_prev;
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_baud_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FCNT_W-1:0] r_count;
    logic                r_overrun;
    logic                r_frame_err;
    logic                r_rd0_prev;
    logic [15:0]         r_d_out;
    logic                r_rx_irq;

    logic                w_bit_tick;
    logic                w_stop_good;
    logic                w_stop_bad;
    logic                w_rd0;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_ctrl_wr;
    logic                w_flush;
    logic                w_push;
    logic                w_ovr_set;
    logic [c_FCNT_W-1:0] w_count_next;
    logic [15:0]         w_status;
    logic                w_unused;

    assign w_bit_tick  = (r_baud_cnt == c_BIT_LAST);
    assign w_stop_good = (r_state == c_ST_STOP) && w_bit_tick && r_sync2;
    assign w_stop_bad  = (r_state == c_ST_STOP) && w_bit_tick && !r_sync2;

    // Pop only on the first cycle of a data-register read, however long rd is held
    assign w_rd0     = cs && rd && (addr == 4'h0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = w_rd0 && !r_rd0_prev && !w_empty;
    assign w_ctrl_wr = cs && wr && (addr == 4'h4);
    assign w_flush   = w_ctrl_wr && d_in[2];

    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign w_push    = w_stop_good && !w_flush && (!w_full || w_pop);
    assign w_ovr_set = w_stop_good && !w_flush && w_full && !w_pop;

    assign w_status = {7'd0, (r_state != c_ST_IDLE), 4'(r_count),
                       r_frame_err, r_overrun, w_full, !w_empty};

    assign d_out    = r_d_out;
    assign rx_irq   = r_rx_irq;
    assign w_unused = &{1'b0, d_in[15:3]};

    // Two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Receive state machine: start-bit qualification, mid-bit sampling, stop check
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_rx_prev && !r_sync2) begin
                        r_state    <= c_ST_START;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                    end
                end
                c_ST_START: begin
                    if (r_baud_cnt == c_HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_state    <= r_sync2 ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_tick) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_tick) begin
                        r_baud_cnt <= '0;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

    // Next FIFO occupancy; flush overrides any push or pop in the same cycle
    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // FIFO storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and the interrupt derived from next occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rx_irq <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            r_count  <= w_count_next;
            r_rx_irq <= (w_count_next != '0);
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_ctrl_wr && d_in[0]) begin
                r_overrun <= 1'b0;
            end
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (w_ctrl_wr && d_in[1]) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    // Registered read data, refreshed on every sampled read strobe, held otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_d_out    <= 16'h0000;
            r_rd0_prev <= 1'b0;
        end else begin
            r_rd0_prev <= w_rd0;
            if (cs && rd) begin
                case (addr)
                    4'h0:    r_d_out <= w_empty ? 16'h0000 : {8'h00, r_mem[r_rd_ptr]};
                    4'h2:    r_d_out <= w_status;
                    default: r_d_out <= 16'h0000;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/peripheral_uart_rx.md
PERIPHERAL_UART_RX -- requirements
Module: peripheral_uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 8, receive FIFO entries; fixed power of two.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 d_in  input  16  write data from the J1 IO bus.
REQ-007 cs  input  1  chip select from the SoC address decoder.
REQ-008 addr  input  4  register offset, J1 io_addr[3:0].
REQ-009 rd  input  1  J1 IO read strobe.
REQ-010 wr  input  1  J1 IO write strobe.
REQ-011 d_out  output  16  read data, registered.
REQ-012 uart_rx  input  1  asynchronous serial input, idle high, 8N1.
REQ-013 rx_irq  output  1  high while the FIFO is non-empty, registered.

Function
REQ-014 uart_rx SHALL pass through a 2-flop synchronizer; all RX logic SHALL use the synchronized value.
REQ-015 RX FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on a synchronized falling edge (previous sample 1, current 0); bit counter cleared.
REQ-017 START: after CLKS_PER_BIT/2 clocks, resample; low -> DATA with baud counter reset; high -> IDLE (glitch, nothing recorded).
REQ-018 DATA: sample every CLKS_PER_BIT clocks, shift in LSB first; after 8th bit -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT clocks; high -> push byte, IDLE; low -> frame_err set, byte discarded, IDLE.
REQ-020 Byte push SHALL occur in the same clock as the stop-bit sample; the byte SHALL be readable on the next clock.
REQ-021 Register map (cs=1): addr 0x0 read = {8'h00, FIFO head}, pops; addr 0x2 read = status; addr 0x4 write = control; other offsets read 16'h0000, writes ignored.
REQ-022 Status bits: [0] not-empty, [1] full, [2] overrun, [3] frame_err, [7:4] FIFO count (0..8), [8] busy (FSM != IDLE), [15:9] zero.
REQ-023 Control write: d_in[0]=1 clears overrun, d_in[1]=1 clears frame_err, d_in[2]=1 flushes FIFO (count 0, pointers equal).
REQ-024 d_out SHALL update on the clock edge where cs&rd is sampled and hold its value otherwise.
REQ-025 Pop SHALL occur once per read access: only on the first cycle of cs&rd&(addr==0x0) (rising edge of that condition), regardless of strobe length.
REQ-026 Read of 0x0 while empty SHALL return 16'h0000 and leave pointers unchanged.
REQ-027 Push while full and no pop that cycle: byte dropped, overrun set, FIFO contents unchanged.
REQ-028 Push and pop same cycle: both performed, count unchanged, no overrun, even when full.
REQ-029 Sticky flag set and clear in the same cycle: set wins.
REQ-030 Flush and push same cycle: flush wins, incoming byte dropped, no overrun.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be one bit wider than pointer.

Reset
REQ-032 While rst=0 at a clock edge: FSM IDLE, counters 0, FIFO empty, overrun=0, frame_err=0, d_out=16'h0000, rx_irq=0, synchronizer flops =1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release the FSM SHALL wait for a new falling edge.

Verification (CLK_FREQ=1000000, BAUD=100000, CLKS_PER_BIT=10)
REQ-034 Send 0xA5, 8N1 -> status 0x0011, rx_irq=1; read 0x0 -> d_out 0x00A5; status then 0x0000, rx_irq=0.
REQ-035 Send 9 bytes 0x01..0x09 with no reads -> status count 8, full=1, overrun=1; 8 reads return 0x01..0x08; write 0x4 d_in=0x0001 -> overrun=0.
REQ-036 Send 0x3C with stop bit low -> frame_err=1, count 0; then valid 0x55 -> count 1, read 0x0055; frame_err stays 1 until write 0x4 d_in=0x0002.
REQ-037 uart_rx low pulse of 3 clocks -> FSM returns to IDLE, count 0, flags 0.
REQ-038 FIFO full, stop-bit sample coincides with first cycle of read 0x0 -> returns oldest byte, count stays 8, overrun=0; rd held 5 cycles pops once.
REQ-039 rst=0 during DATA bit 4 of a frame, released -> status 0x0000, remaining bits ignored; next full frame 0x7E received correctly.
